is_l15_resp_model: RTL



---
 rtl/is_l15_resp_model.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/is_l15_resp_model.sv
// is_l15_resp_model: in-order L1.5 responder with a small backing store.
// Define IS_L15_MODEL_AMO_EN to enable AMO read-modify-write (ADD/SWAP).
module is_l15_resp_model #(
    parameter int DEPTH     = 4,
    parameter int LATENCY   = 3,
    parameter int MEM_WORDS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        transducer_l15_val,
    input  logic [4:0]  transducer_l15_rqtype,
    input  logic [3:0]  transducer_l15_amo_op,
    input  logic [2:0]  transducer_l15_size,
    input  logic [39:0] transducer_l15_address,
    input  logic [63:0] transducer_l15_data,
    input  logic [0:0]  transducer_l15_threadid,
    input  logic        transducer_l15_req_ack,
    output logic        l15_transducer_header_ack,
    output logic        l15_transducer_ack,
    output logic        l15_transducer_val,
    output logic [3:0]  l15_transducer_returntype,
    output logic [0:0]  l15_transducer_threadid,
    output logic [63:0] l15_transducer_data_0,
    output logic [63:0] l15_transducer_data_1
);
    localparam logic [4:0] LOAD_RQ         = 5'b00000;
    localparam logic [4:0] STORE_RQ        = 5'b00001;
    localparam logic [4:0] PCX_REQTYPE_AMO = 5'b00110;

    localparam logic [3:0] LOAD_RET               = 4'b0000;
    localparam logic [3:0] ST_ACK                 = 4'b0100;
    localparam logic [3:0] CPX_RESTYPE_ATOMIC_RES = 4'b1110;

`ifdef IS_L15_MODEL_AMO_EN
    localparam logic [3:0] L15_AMO_OP_SWAP = 4'b0011;
    localparam logic [3:0] L15_AMO_OP_ADD  = 4'b0100;
`endif

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [3:0] CD_INIT = 4'(LATENCY - 1);

    logic [63:0]   mem    [MEM_WORDS];
    logic [3:0]    q_rt   [DEPTH];
    logic [0:0]    q_tid  [DEPTH];
    logic [63:0]   q_data [DEPTH];
    logic [3:0]    q_cd   [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] count;

    logic          val_q;
    logic [3:0]    rt_q;
    logic [0:0]    tid_q;
    logic [63:0]   data_q;

    logic          push;
    logic          pop;
    logic          head_ready;
    logic [2:0]    off;
    logic [AW-1:0] widx;
    logic [63:0]   old_word;
    logic [63:0]   shifted;
    logic [63:0]   wr_word;
    logic [63:0]   push_data;
    logic [3:0]    push_rt;
    logic [3:0]    nbytes;
    logic [7:0]    lane_en;
    logic          mem_we;
    logic          is_load;
    logic          is_store;
    logic          is_amo;
    logic          unused_bits;

    assign unused_bits = ^{transducer_l15_address[39:3+AW],
                           transducer_l15_amo_op};

    // full is judged on the registered count; a same-cycle pop frees nothing
    assign push = transducer_l15_val && !rst
               && (count < CW'(DEPTH));
    assign pop  = val_q && transducer_l15_req_ack;
    assign head_ready = (count != '0) && (q_cd[rptr] == 4'd0);

    always_comb begin
        off      = transducer_l15_address[2:0];
        widx     = transducer_l15_address[3 +: AW];
        old_word = mem[widx];
        nbytes   = (transducer_l15_size >= 3'd3) ? 4'd8
                 : (4'd1 << transducer_l15_size[1:0]);
        shifted  = transducer_l15_data << {off, 3'b000};
        // lanes past byte 7 simply fall off the word
        for (int b = 0; b < 8; b++) begin
            lane_en[b] = (4'(b) >= {1'b0, off})
                      && ((4'(b) - {1'b0, off}) < nbytes);
        end
        is_load   = transducer_l15_rqtype == LOAD_RQ;
        is_store  = transducer_l15_rqtype == STORE_RQ;
        is_amo    = transducer_l15_rqtype == PCX_REQTYPE_AMO;
        mem_we    = 1'b0;
        wr_word   = old_word;
        push_rt   = LOAD_RET;
        push_data = '0;
        unique case (1'b1)
            is_load: begin
                push_data = old_word;
            end
            is_store: begin
                push_rt = ST_ACK;
                mem_we  = 1'b1;
                for (int b = 0; b < 8; b++) begin
                    if (lane_en[b]) begin
                        wr_word[8*b +: 8] = shifted[8*b +: 8];
                    end
                end
            end
            is_amo: begin
                push_rt = CPX_RESTYPE_ATOMIC_RES;
`ifdef IS_L15_MODEL_AMO_EN
                push_data = old_word;
                if (transducer_l15_amo_op == L15_AMO_OP_ADD) begin
                    mem_we  = 1'b1;
                    wr_word = old_word + transducer_l15_data;
                end else if (transducer_l15_amo_op == L15_AMO_OP_SWAP) begin
                    mem_we  = 1'b1;
                    wr_word = transducer_l15_data;
                end
`endif
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (push && mem_we) begin
            mem[widx] <= wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= '0;
            wptr   <= '0;
            rptr   <= '0;
            val_q  <= 1'b0;
            rt_q   <= '0;
            tid_q  <= '0;
            data_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_rt[i]   <= '0;
                q_tid[i]  <= '0;
                q_data[i] <= '0;
                q_cd[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (q_cd[i] != 4'd0) begin
                    q_cd[i] <= q_cd[i] - 4'd1;
                end
            end
            if (push) begin
                q_rt[wptr]   <= push_rt;
                q_tid[wptr]  <= transducer_l15_threadid;
                q_data[wptr] <= push_data;
                q_cd[wptr]   <= CD_INIT;
                wptr         <= wptr + PW'(1);
            end
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
            // a popped head leaves one idle cycle before the next one shows
            val_q <= head_ready && !pop;
            if (head_ready && !pop) begin
                rt_q   <= q_rt[rptr];
                tid_q  <= q_tid[rptr];
                data_q <= q_data[rptr];
            end
        end
    end

    assign l15_transducer_header_ack = push;
    assign l15_transducer_ack        = push;
    assign l15_transducer_val        = val_q;
    assign l15_transducer_returntype = rt_q;
    assign l15_transducer_threadid   = tid_q;
    assign l15_transducer_data_0     = data_q;
    assign l15_transducer_data_1     = data_q;

endmodule
